// File: rtl/md_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide sequencer.
package md_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_SEND,
    S_DIV_WAIT,
    S_DRAIN
  } md_state_e;

  localparam int MUL_W      = 33;
  localparam int DIV_W      = 40;
  localparam int DIVP_Q_LSB = 40;
  localparam int DIVP_R_LSB = 0;

  // op[0] clear means signed (MULT/DIV)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic [MUL_W-1:0] ext_mul(input logic [31:0] v, input logic sgn);
    return {{(MUL_W-32){sgn & v[31]}}, v};
  endfunction

  function automatic logic [DIV_W-1:0] ext_div(input logic [31:0] v, input logic sgn);
    return {{(DIV_W-32){sgn & v[31]}}, v};
  endfunction

endpackage

// File: rtl/md_sequencer_axis_pair_send.sv
// Dividend/divisor AXI-stream senders; each channel completes independently.
module md_axis_pair_send (
  input  logic clk,
  input  logic resetn,
  input  logic start_i,
  input  logic active_i,
  input  logic a_ready_i,
  input  logic b_ready_i,
  output logic a_valid_o,
  output logic b_valid_o,
  output logic both_done_o
);

  logic a_done_q, b_done_q;
  logic a_hs, b_hs;

  // valid depends only on state and done bits, so it cannot drop before its handshake
  assign a_valid_o   = active_i && !a_done_q;
  assign b_valid_o   = active_i && !b_done_q;
  assign a_hs        = a_valid_o && a_ready_i;
  assign b_hs        = b_valid_o && b_ready_i;
  assign both_done_o = active_i && (a_done_q || a_hs) && (b_done_q || b_hs);

  always_ff @(posedge clk) begin
    if (!resetn || start_i) begin
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
    end else begin
      if (a_hs) a_done_q <= 1'b1;
      if (b_hs) b_done_q <= 1'b1;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer: drives the pipelined multiplier and the
// AXI-stream divider, returns a one-cycle HI/LO write, drains on flush.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_LAT = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [1:0]         issue_op,
  input  logic [31:0]        issue_a,
  input  logic [31:0]        issue_b,
  input  logic               flush,
  output logic [MUL_W-1:0]   mult_a,
  output logic [MUL_W-1:0]   mult_b,
  input  logic [65:0]        mult_p,
  output logic               div_a_valid,
  output logic [DIV_W-1:0]   div_a_data,
  input  logic               div_a_ready,
  output logic               div_b_valid,
  output logic [DIV_W-1:0]   div_b_data,
  input  logic               div_b_ready,
  input  logic               div_p_valid,
  input  logic [79:0]        div_p_data,
  output logic               hilo_we,
  output logic [31:0]        hilo_hi,
  output logic [31:0]        hilo_lo,
  output logic               busy,
  output logic               hilo_pending
);

  localparam int CW = (MULT_LAT < 1) ? 1 : $clog2(MULT_LAT + 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  md_op_e        op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          kill_q, kill_d;
  logic          we_q, we_d;
  logic          accept, sgn, both_done;
  logic          unused_bits;

  assign issue_ready  = (state_q == S_IDLE) && !flush;
  assign accept       = issue_valid && issue_ready;
  assign sgn          = op_is_signed(op_q);
  assign mult_a       = ext_mul(a_q, sgn);
  assign mult_b       = ext_mul(b_q, sgn);
  assign div_a_data   = ext_div(a_q, sgn);
  assign div_b_data   = ext_div(b_q, sgn);
  assign hilo_we      = we_q;
  assign hilo_hi      = hi_q;
  assign hilo_lo      = lo_q;
  assign busy         = (state_q != S_IDLE);
  assign hilo_pending = (((state_q == S_MUL) || (state_q == S_DIV_SEND) ||
                          (state_q == S_DIV_WAIT)) && !kill_q) || we_q;
  assign unused_bits  = ^{mult_p[65:64], div_p_data[79:72], div_p_data[39:32]};

  md_axis_pair_send u_send (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (accept),
    .active_i    (state_q == S_DIV_SEND),
    .a_ready_i   (div_a_ready),
    .b_ready_i   (div_b_ready),
    .a_valid_o   (div_a_valid),
    .b_valid_o   (div_b_valid),
    .both_done_o (both_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    kill_d  = kill_q;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = md_op_e'(issue_op);
          a_d     = issue_a;
          b_d     = issue_b;
          cnt_d   = '0;
          kill_d  = 1'b0;
          state_d = op_is_div(issue_op) ? S_DIV_SEND : S_MUL;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(MULT_LAT)) begin
          hi_d    = mult_p[63:32];
          lo_d    = mult_p[31:0];
          we_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV_SEND: begin
        // the divider cannot be aborted: finish both sends, then drain the result
        if (flush) kill_d = 1'b1;
        if (both_done) state_d = (kill_q || flush) ? S_DRAIN : S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        if (div_p_valid) begin
          if (!flush) begin
            lo_d = div_p_data[DIVP_Q_LSB +: 32];
            hi_d = div_p_data[DIVP_R_LSB +: 32];
            we_d = 1'b1;
          end
          state_d = S_IDLE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (div_p_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      kill_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      kill_q  <= kill_d;
      we_q    <= we_d;
    end
  end

endmodule
